// File: rtl/rtr_ovc_credit_tracker_pkg.sv
// Shared constants and index helpers for the output-VC credit tracker.
// No types are defined here. The package holds only the width helper and the
// index arithmetic that the tracker and its counters share.
package rtr_ovc_credit_tracker_pkg;

  // Ceiling log2. This gives the bits needed to encode values 0..value-1.
  function automatic int clogb(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Packet class index from a (message class, resource class) pair.
  function automatic int opc_index(input int mc, input int rc, input int nrc);
    return mc * nrc + rc;
  endfunction

  // Port-major flag bit index: port 0 class 0 is bit 0.
  function automatic int flag_index(input int port, input int opc, input int npc);
    return port * npc + opc;
  endfunction

endpackage

// File: rtl/rtr_credit_counter.sv
// Single downstream credit counter for one (output port, packet class) pair.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   inc               credit returned this cycle
//   dec               credit consumed by a departing flit this cycle
//   cnt               free credits
//   full              no credits left
//   almost_full       exactly one credit left
//   empty             all buffer_size credits present
//   error             sticky underflow/overflow
module rtr_credit_counter
  import rtr_ovc_credit_tracker_pkg::*;
#(
  parameter int buffer_size = 8,
  parameter int cred_width  = clogb(buffer_size + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  output logic [cred_width-1:0] cnt,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  error
);

  localparam logic [cred_width-1:0] cnt_max = cred_width'(buffer_size);
  localparam logic [cred_width-1:0] cnt_one = cred_width'(1);

  // A consume and a return in the same cycle cancel out. Neither one is
  // checked for protocol limits in that case.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= cnt_max;
      error <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b01: begin
          if (cnt == '0) error <= 1'b1;
          else           cnt   <= cnt - cnt_one;
        end
        2'b10: begin
          if (cnt == cnt_max) error <= 1'b1;
          else                cnt   <= cnt + cnt_one;
        end
        default: ;
      endcase
    end
  end

  assign full        = (cnt == '0);
  assign almost_full = (cnt == cnt_one);
  assign empty       = (cnt == cnt_max);

endmodule

// File: rtl/rtr_ovc_credit_tracker.sv
// Output-side credit tracker. Keeps one credit counter per (output port,
// packet class) pair and packs their flags for the flag-selection logic.
// All flag vectors are [0:N-1] with bit index = port*num_packet_classes + opc.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flit_valid            a flit departs this cycle and consumes one credit
//   flit_op               one-hot output port of the departing flit
//   flit_opc              one-hot packet class of the departing flit
//   cred_valid_op         per-port credit return strobe
//   cred_opc_op           per-port one-hot class of the returned credit
//   full_op_opc           no credits left
//   almost_full_op_opc    exactly one credit left
//   empty_op_opc          downstream buffer empty (all credits present)
//   error_op_opc          sticky credit underflow/overflow
module rtr_ovc_credit_tracker
  import rtr_ovc_credit_tracker_pkg::*;
#(
  parameter  int num_message_classes  = 2,
  parameter  int num_resource_classes = 2,
  parameter  int num_ports            = 5,
  parameter  int buffer_size          = 8,
  localparam int num_packet_classes   = num_message_classes * num_resource_classes,
  localparam int num_flags            = num_ports * num_packet_classes,
  localparam int cred_width           = clogb(buffer_size + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flit_valid,
  input  logic [0:num_ports-1]        flit_op,
  input  logic [0:num_packet_classes-1] flit_opc,
  input  logic [0:num_ports-1]        cred_valid_op,
  input  logic [0:num_flags-1]        cred_opc_op,
  output logic [0:num_flags-1]        full_op_opc,
  output logic [0:num_flags-1]        almost_full_op_opc,
  output logic [0:num_flags-1]        empty_op_opc,
  output logic [0:num_flags-1]        error_op_opc
);

  logic [cred_width-1:0] cnt_q [num_flags];

  // Departing flits must carry one-hot port and class selects.
  assert property (@(posedge clk) disable iff (reset)
    flit_valid |-> ($onehot(flit_op) && $onehot(flit_opc)));

  for (genvar p = 0; p < num_ports; p++) begin : g_port
    assert property (@(posedge clk) disable iff (reset)
      cred_valid_op[p] |-> $onehot(cred_opc_op[p*num_packet_classes +: num_packet_classes]));

    for (genvar c = 0; c < num_packet_classes; c++) begin : g_class
      localparam int idx = flag_index(p, c, num_packet_classes);

      logic dec;
      logic inc;

      assign dec = flit_valid & flit_op[p] & flit_opc[c];
      assign inc = cred_valid_op[p] & cred_opc_op[idx];

      rtr_credit_counter #(
        .buffer_size (buffer_size),
        .cred_width  (cred_width)
      ) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .inc         (inc),
        .dec         (dec),
        .cnt         (cnt_q[idx]),
        .full        (full_op_opc[idx]),
        .almost_full (almost_full_op_opc[idx]),
        .empty       (empty_op_opc[idx]),
        .error       (error_op_opc[idx])
      );

      // The counter saturates, so it can never hold more than buffer_size.
      assert property (@(posedge clk) disable iff (reset)
        cnt_q[idx] <= cred_width'(buffer_size));
    end
  end

endmodule
